// File: rtl/insn_encoder_loader.sv
// Encodes instruction field requests into 32-bit words and streams them, with
// incrementing word addresses, through a 2-entry FIFO to the imem write port.
module insn_encoder_loader #(
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic              in_last,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_aluop,
    input  logic [16:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_insn,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   n_written
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] addr_mem [2];
    logic [31:0]       insn_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count;
    logic [31:0]       enc;
    logic              push, pop, full;

    always_comb begin
        enc = '0;
        unique case (in_kind)
            2'd0:    enc = {5'b00000, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
            2'd1:    enc = {5'b00101, in_rd, in_rs, in_imm};
            2'd2:    enc = {5'b00111, in_rd, in_rs, in_imm};
            default: enc = {5'b01000, in_rd, in_rs, in_imm};
        endcase
    end

    // Pointers are single bits: the buffer depth is fixed at two.
    assign full      = (count == FIFO_DEPTH[1:0]);
    assign in_ready  = (state == LOAD) && !full;
    assign out_valid = (count != 2'd0);
    assign out_addr  = addr_mem[rd_ptr];
    assign out_insn  = insn_mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= '0;
            n_written <= '0;
            for (int i = 0; i < 2; i++) begin
                addr_mem[i] <= '0;
                insn_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_mem[wr_ptr] <= addr_cnt;
                insn_mem[wr_ptr] <= enc;
                wr_ptr           <= ~wr_ptr;
                addr_cnt         <= addr_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= ~rd_ptr;
                n_written <= n_written + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase

            unique case (state)
                IDLE: if (start) begin
                    state     <= LOAD;
                    addr_cnt  <= base_addr;
                    n_written <= '0;
                end
                LOAD: if (push && in_last) state <= DRAIN;
                // Leave as soon as the final word is popping, not a cycle later.
                DRAIN: if (count == 2'd0 || (pop && count == 2'd1)) state <= FIN;
                FIN:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_insn_encoder_loader.sv
// Directed bench for insn_encoder_loader: a queue/session model checked every
// cycle, plus literal expectations on the words actually written.
module tb_insn_encoder_loader;

    logic        clock = 1'b0;
    logic        reset, start, in_valid, in_last, out_ready;
    logic [11:0] base_addr;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd, in_rs, in_rt, in_shamt, in_aluop;
    logic [16:0] in_imm;
    logic        in_ready, out_valid, busy, done;
    logic [11:0] out_addr;
    logic [31:0] out_insn;
    logic [12:0] n_written;

    insn_encoder_loader #(.ADDR_W(12), .FIFO_DEPTH(2)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_last(in_last),
        .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt),
        .in_aluop(in_aluop), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_insn(out_insn), .busy(busy), .done(done),
        .n_written(n_written)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_enc(input int unsigned kind, rd, rs, rt, sh, op, imm);
        int unsigned opc;
        case (kind)
            0: opc = 0;
            1: opc = 5;
            2: opc = 7;
            default: opc = 8;
        endcase
        if (kind == 0)
            return opc * 2**27 + rd * 2**22 + rs * 2**17 + rt * 2**12 + sh * 2**7 + op * 4;
        return opc * 2**27 + rd * 2**22 + rs * 2**17 + imm;
    endfunction

    typedef struct { logic [11:0] a; logic [31:0] w; } word_t;
    word_t       q[$];
    logic [11:0] log_a[$];
    logic [31:0] log_w[$];
    logic        m_ready = 1'b0, m_load, m_drain, m_fin;
    logic [11:0] m_addr;
    logic [12:0] m_nw;

    // Session model: buffered words as a queue, session phase as flags.
    always @(posedge clock) begin
        bit idle, acc_in, acc_out;
        if (reset) begin
            q.delete();
            m_load = 0; m_drain = 0; m_fin = 0; m_addr = 0; m_nw = 0; m_ready = 1;
        end else if (m_ready) begin
            if (out_valid && out_ready) begin
                log_a.push_back(out_addr);
                log_w.push_back(out_insn);
            end
            idle    = !(m_load || m_drain || m_fin);
            acc_in  = m_load && q.size() < 2 && in_valid;
            acc_out = q.size() > 0 && out_ready;
            m_fin   = 0;
            if (start && idle) begin
                m_load = 1; m_addr = base_addr; m_nw = 0;
            end
            if (acc_out) begin
                void'(q.pop_front());
                m_nw++;
            end
            if (acc_in) begin
                q.push_back('{m_addr, model_enc(in_kind, in_rd, in_rs, in_rt, in_shamt, in_aluop, in_imm)});
                m_addr++;
                if (in_last) begin m_load = 0; m_drain = 1; end
            end
            if (m_drain && q.size() == 0) begin m_drain = 0; m_fin = 1; end
        end
    end

    always @(negedge clock) begin
        if (m_ready) begin
            chk("in_ready", in_ready, m_load && q.size() < 2);
            chk("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("out_addr", out_addr, q[0].a);
                chk("out_insn", out_insn, q[0].w);
            end
            chk("busy", busy, m_load || m_drain || m_fin);
            chk("done", done, m_fin);
            chk("n_written", n_written, m_nw);
        end
    end

    task automatic set_req(input int k, rd, rs, rt, sh, op, imm, input bit last);
        in_kind = 2'(k); in_rd = 5'(rd); in_rs = 5'(rs); in_rt = 5'(rt);
        in_shamt = 5'(sh); in_aluop = 5'(op); in_imm = 17'(imm); in_last = last;
    endtask

    task automatic accept_wait();
        int n = 0;
        in_valid = 1;
        while (!in_ready && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) begin errors++; checks++; $display("FAIL accept_timeout: in_ready stayed 0"); end
        @(negedge clock);
        in_valid = 0;
    endtask

    task automatic send(input int k, rd, rs, rt, sh, op, imm, input bit last);
        set_req(k, rd, rs, rt, sh, op, imm, last);
        accept_wait();
    endtask

    task automatic do_start(input logic [11:0] b);
        start = 1; base_addr = b;
        @(negedge clock);
        start = 0;
    endtask

    task automatic wait_done(input int exp_nw);
        int n = 0;
        while (!done && n < 50) begin @(negedge clock); n++; end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL done_timeout: done never rose"); end
        chk("n_written_at_done", n_written, exp_nw);
        @(negedge clock);
        chk("done_one_cycle", done, 0);
        chk("busy_after_fin", busy, 0);
    endtask

    task automatic chk_log(input int idx, input logic [11:0] a, input logic [31:0] w);
        checks++;
        if (idx >= log_a.size()) begin
            errors++;
            $display("FAIL log_missing: word %0d got none expected %h@%h", idx, w, a);
        end else begin
            checks--;
            chk($sformatf("log_addr[%0d]", idx), log_a[idx], a);
            chk($sformatf("log_insn[%0d]", idx), log_w[idx], w);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_insn", out_insn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_n_written", n_written, 0);
    endtask

    initial begin
        reset = 1; start = 0; base_addr = 0; in_valid = 0; out_ready = 0;
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clock);
        chk_reset_vals();
        reset = 0;
        @(negedge clock);

        // single ALU word, last immediately
        out_ready = 1;
        do_start(12'h010);
        send(0, 3, 1, 2, 0, 0, 0, 1);
        wait_done(1);
        chk_log(0, 12'h010, 32'h00C22000);

        // addi / sw / lw back to back
        do_start(12'h020);
        send(1, 1, 0, 0, 0, 0, 5, 0);
        send(2, 1, 2, 0, 0, 0, 17'h1FFFF, 0);
        send(3, 4, 2, 0, 0, 0, 0, 1);
        wait_done(3);
        chk_log(1, 12'h020, 32'h28400005);
        chk_log(2, 12'h021, 32'h3845FFFF);
        chk_log(3, 12'h022, 32'h41040000);

        // backpressure: FIFO fills, third request waits
        out_ready = 0;
        do_start(12'h100);
        send(0, 5, 6, 7, 8, 9, 0, 0);
        send(1, 2, 3, 0, 0, 0, 17'h10, 0);
        set_req(3, 1, 1, 0, 0, 0, 17'hABC, 1);
        in_valid = 1;
        repeat (3) @(negedge clock);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        chk("full_out_addr", out_addr, 12'h100);
        chk("full_out_insn", out_insn, 32'h014C7424);
        out_ready = 1;
        accept_wait();
        wait_done(3);
        chk_log(4, 12'h100, 32'h014C7424);
        chk_log(5, 12'h101, 32'h28860010);
        chk_log(6, 12'h102, 32'h40420ABC);

        // address wrap
        do_start(12'hFFF);
        send(1, 1, 1, 0, 0, 0, 1, 0);
        send(2, 0, 0, 0, 0, 0, 0, 1);
        wait_done(2);
        chk_log(7, 12'hFFF, 32'h28420001);
        chk_log(8, 12'h000, 32'h38000000);

        // last accepted while one word pops; all-ones fields
        do_start(12'h040);
        send(0, 31, 31, 31, 31, 31, 0, 0);
        send(1, 31, 31, 0, 0, 0, 17'h1FFFF, 1);
        wait_done(2);
        chk_log(9, 12'h040, 32'h07FFFFFC);
        chk_log(10, 12'h041, 32'h2FFFFFFF);

        // reset mid-session after one pop
        out_ready = 0;
        do_start(12'h200);
        send(1, 1, 1, 0, 0, 0, 1, 0);
        send(1, 2, 2, 0, 0, 0, 2, 0);
        out_ready = 1;
        @(negedge clock);
        out_ready = 0;
        chk("pre_reset_n_written", n_written, 1);
        reset = 1;
        @(negedge clock);
        chk_reset_vals();
        reset = 0;
        @(negedge clock);
        chk("post_reset_done", done, 0);
        chk_log(11, 12'h200, 32'h28420001);

        // start during LOAD must be ignored
        out_ready = 1;
        do_start(12'h300);
        send(3, 1, 1, 0, 0, 0, 7, 0);
        start = 1; base_addr = 12'h555;
        @(negedge clock);
        start = 0;
        send(2, 2, 2, 0, 0, 0, 9, 1);
        wait_done(2);
        chk_log(12, 12'h300, 32'h40420007);
        chk_log(13, 12'h301, 32'h38840009);
        chk("log_count", log_a.size(), 14);

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
